// File: rtl/disp_scan_pkg.sv
// rtl/disp_scan_pkg.sv - shared types and constants for the display scan controller
package disp_scan_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  localparam int NIBBLE_W       = 4;
  localparam int DEF_NUM_DIGITS = 4;

endpackage

// File: rtl/scan_dwell_timer.sv
// rtl/scan_dwell_timer.sv - loadable down-counter that parks at zero and flags done there
module scan_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - time-multiplexed digit scanner with one-deep frame buffer
// Build option LEADING_ZERO_BLANK_EN: digits above the top nonzero digit stay dark.
module display_scan_controller
  import disp_scan_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIV_WIDTH  = 16,
  parameter int GAP_CYCLES = 2,
  localparam int IDX_W   = $clog2(NUM_DIGITS),
  localparam int FRAME_W = NIBBLE_W * NUM_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  div_val,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [FRAME_W-1:0]    frame_data,
  output logic [NIBBLE_W-1:0]   nibble_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW    = (DIV_WIDTH > GAP_W) ? DIV_WIDTH : GAP_W;
  localparam logic [TW-1:0]    GAP_LOAD = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      next_idx;
  logic [FRAME_W-1:0]    active;
  logic [FRAME_W-1:0]    pending;
  logic [FRAME_W-1:0]    next_active;
  logic                  pending_full;
  logic                  timer_load;
  logic [TW-1:0]         timer_val;
  logic                  timer_done;
  logic                  last_digit;
  logic                  slot_end;
  logic                  wrap;
  logic                  boundary;
  logic                  xfer;
  logic                  enter_show;
  logic                  enter_gap;
  logic [NUM_DIGITS-1:0] show_onehot;
  logic [NUM_DIGITS-1:0] lit;

  scan_dwell_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign frame_ready = ~pending_full;
  assign xfer        = frame_valid & ~pending_full;
  assign last_digit  = (idx == LAST_IDX);
  // With no gap configured, a slot ends on the final SHOW cycle itself.
  assign slot_end    = (GAP_CYCLES == 0) ? (state == ST_SHOW && timer_done)
                                         : (state == ST_GAP && timer_done);
  assign wrap        = enable & slot_end & last_digit;
  assign boundary    = (state == ST_OFF) | wrap;
  assign enter_show  = enable & ((state == ST_OFF) | slot_end);
  assign enter_gap   = enable & (GAP_CYCLES > 0) & (state == ST_SHOW) & timer_done;
  assign timer_load  = enter_show | enter_gap;
  assign timer_val   = enter_gap ? GAP_LOAD : TW'(div_val);
  assign show_onehot = NUM_DIGITS'(1) << idx;

  always_comb begin
    next_idx = '0;
    if (state != ST_OFF && !last_digit) next_idx = idx + 1'b1;
  end

  // Pending wins at a boundary; a same-cycle offer goes straight to active only when pending is empty.
  always_comb begin
    next_active = active;
    if (boundary) begin
      if (pending_full)     next_active = pending;
      else if (frame_valid) next_active = frame_data;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen;
`endif

  always_comb begin
    lit = '1;
`ifdef LEADING_ZERO_BLANK_EN
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen   = seen | (active[NIBBLE_W*i +: NIBBLE_W] != '0);
      lit[i] = seen;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_OFF;
      idx          <= '0;
      nibble_out   <= '0;
      digit_idx    <= '0;
      digit_en     <= '0;
      frame_done   <= 1'b0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      // Enables trail the nibble by one clock to line up with the registered segment converter.
      digit_en   <= (state == ST_SHOW) ? (show_onehot & lit) : '0;
      frame_done <= wrap;

      if (boundary) begin
        active       <= next_active;
        pending_full <= 1'b0;
      end else if (xfer) begin
        pending      <= frame_data;
        pending_full <= 1'b1;
      end

      if (!enable) begin
        state <= ST_OFF;
        idx   <= '0;
      end else if (enter_show) begin
        state      <= ST_SHOW;
        idx        <= next_idx;
        digit_idx  <= next_idx;
        nibble_out <= next_active[NIBBLE_W*next_idx +: NIBBLE_W];
      end else if (enter_gap) begin
        state <= ST_GAP;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - randomized check of the scan controller against a slot-arithmetic model
module tb_display_scan_controller;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int G  = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] div_val;
  logic          frame_valid;
  logic          frame_ready;
  logic [15:0]   frame_data;
  logic [3:0]    nibble_out;
  logic [3:0]    digit_en;
  logic [1:0]    digit_idx;
  logic          frame_done;

  logic          en_z;
  logic [DW-1:0] div_z;
  logic          fv_z;
  logic          z_ready;
  logic [15:0]   fd_z;
  logic [3:0]    z_nib;
  logic [3:0]    z_en;
  logic [1:0]    z_idx;
  logic          z_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_active, m_pend;
  bit          m_pv, m_on, m_done;
  int          m_p, m_d, m_idx;
  logic [3:0]  m_nib, m_en;

  always #5 clock = ~clock;

  display_scan_controller #(.NUM_DIGITS(N), .DIV_WIDTH(DW), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .enable(enable), .div_val(div_val),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .nibble_out(nibble_out), .digit_en(digit_en), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  display_scan_controller #(.NUM_DIGITS(N), .DIV_WIDTH(DW), .GAP_CYCLES(0)) dut_nogap (
    .clock(clock), .reset(reset), .enable(en_z), .div_val(div_z),
    .frame_valid(fv_z), .frame_ready(z_ready), .frame_data(fd_z),
    .nibble_out(z_nib), .digit_en(z_en), .digit_idx(z_idx), .frame_done(z_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] lit_mask(input logic [15:0] f);
    logic [3:0] m;
    m = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
    m = 4'b0001;
    for (int i = 1; i < N; i++) if ((f >> (4*i)) != 16'h0) m[i] = 1'b1;
`endif
    return m;
  endfunction

  task automatic model_reset();
    m_active = '0; m_pend = '0; m_pv = 0; m_on = 0; m_done = 0;
    m_p = 0; m_d = 0; m_idx = 0; m_nib = '0; m_en = '0;
  endtask

  // Scanning is a repeating frame of N slots, each div+1 lit clocks plus G dark clocks.
  task automatic model_edge(input bit en, input int dv, input bit fv, input logic [15:0] fd);
    int l, fl;
    bit wrap, bnd;
    logic [15:0] old;
    l    = m_d + 1 + G;
    fl   = N * l;
    wrap = m_on && en && (m_p == fl - 1);
    bnd  = !m_on || wrap;
    old  = m_active;
    m_en   = (m_on && (m_p % l) <= m_d) ? (4'(1) << (m_p / l)) & lit_mask(old) : 4'b0;
    m_done = wrap;
    if (bnd) begin
      if (m_pv) begin m_active = m_pend; m_pv = 0; end
      else if (fv) m_active = fd;
    end else if (fv && !m_pv) begin
      m_pend = fd; m_pv = 1;
    end
    if (!en) m_on = 0;
    else if (!m_on) begin m_on = 1; m_p = 0; m_d = dv; end
    else m_p = (m_p + 1) % fl;
    if (m_on) begin
      l = m_d + 1 + G;
      if (m_p % l == 0) begin
        m_idx = m_p / l;
        m_nib = m_active[4*m_idx +: 4];
      end
    end
  endtask

  task automatic step();
    model_edge(enable, int'(div_val), frame_valid, frame_data);
    @(posedge clock);
    @(negedge clock);
    chk("nibble_out", nibble_out, m_nib);
    chk("digit_idx", digit_idx, m_idx);
    chk("digit_en", digit_en, m_en);
    chk("frame_done", frame_done, m_done);
    chk("frame_ready", frame_ready, !m_pv);
  endtask

  initial begin
    int t;
    logic [3:0] seen;
    reset = 1; enable = 0; div_val = 0; frame_valid = 0; frame_data = 0;
    en_z = 0; div_z = 0; fv_z = 0; fd_z = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_digit_en", digit_en, 4'h0);
    chk("rst_nibble", nibble_out, 4'h0);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_ready", frame_ready, 1'b1);

    div_val = 3; frame_valid = 1; frame_data = 16'h1234;
    step();
    frame_valid = 0;
    chk("off_load_ready", frame_ready, 1'b1);
    enable = 1;
    for (int k = 1; k <= 49; k++) begin
      step();
      if (k == 1)  begin chk("f1234_k1_nib", nibble_out, 4'h4); chk("f1234_k1_en", digit_en, 4'h0); end
      if (k == 2)  chk("f1234_k2_en", digit_en, 4'b0001);
      if (k == 5)  chk("f1234_k5_en", digit_en, 4'b0001);
      if (k == 6)  chk("f1234_k6_en", digit_en, 4'b0000);
      if (k == 7)  begin chk("f1234_k7_nib", nibble_out, 4'h3); chk("f1234_k7_idx", digit_idx, 2'd1); end
      if (k == 8)  chk("f1234_k8_en", digit_en, 4'b0010);
      if (k == 24) chk("f1234_k24_done", frame_done, 1'b0);
      if (k == 25) begin
        chk("f1234_k25_done", frame_done, 1'b1);
        chk("f1234_k25_nib", nibble_out, 4'h4);
        frame_valid = 1; frame_data = 16'h5555;
      end
      if (k == 26) begin frame_valid = 0; chk("pend_k26_ready", frame_ready, 1'b0); end
      if (k == 48) begin chk("pend_k48_ready", frame_ready, 1'b0); chk("pend_k48_nib", nibble_out, 4'h1); end
      if (k == 49) begin chk("pend_k49_ready", frame_ready, 1'b1); chk("pend_k49_nib", nibble_out, 4'h5); end
    end

    t = 0;
    while (digit_en !== 4'b0010 && t < 100) begin step(); t++; end
    chk("wait_digit1", t < 100, 1'b1);
    enable = 0;
    step();
    chk("off_k1_en", digit_en, 4'b0010);
    step();
    chk("off_k2_en", digit_en, 4'b0000);
    enable = 1;
    step();
    chk("reen_idx", digit_idx, 2'd0);
    chk("reen_nib", nibble_out, 4'h5);
    frame_valid = 1; frame_data = 16'hAAAA;
    step();
    frame_valid = 0;
    chk("rst_pre_ready", frame_ready, 1'b0);
    t = 0;
    while (digit_en !== 4'b0100 && t < 100) begin step(); t++; end
    chk("wait_digit2", t < 100, 1'b1);
    #2 reset = 1;
    #1;
    chk("async_rst_en", digit_en, 4'h0);
    chk("async_rst_nib", nibble_out, 4'h0);
    chk("async_rst_ready", frame_ready, 1'b1);
    chk("async_rst_idx", digit_idx, 2'd0);
    model_reset();
    enable = 0;
    repeat (2) @(negedge clock);
    reset = 0;

    div_val = 1; frame_valid = 1; frame_data = 16'h0070;
    step();
    frame_valid = 0; enable = 1; seen = '0;
    for (int k = 0; k < 18; k++) begin
      step();
      seen |= digit_en;
    end
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_0070_lit", seen, 4'b0011);
`else
    chk("lzb_0070_lit", seen, 4'b1111);
`endif
    enable = 0;
    step();

    fv_z = 1; fd_z = 16'h4321;
    step();
    fv_z = 0; en_z = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("nogap_nib", z_nib, 4'(((k - 1) % 4) + 1));
      if (k >= 2) chk("nogap_en", z_en, 4'(1) << ((k - 2) % 4));
      if (k == 4) chk("nogap_done_k4", z_done, 1'b0);
      if (k == 5) chk("nogap_done_k5", z_done, 1'b1);
    end
    en_z = 0;

    for (int c = 0; c < 4000; c++) begin
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1;
      end else begin
        div_val = DW'($urandom_range(0, 4));
      end
      frame_valid = 1'($urandom_range(0, 1));
      frame_data  = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
